// File: rtl/mframe_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mframe_serializer
// Brief    : Ping-pong RAM telemetry frame serializer with frame markers,
//            half-bit slot output, parallel word copy and BCD seconds count.
// Revision : 1.0
// ============================================================================
module mframe_serializer #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10,
    parameter int DIV    = 4,
    parameter int WRDS   = 8,
    parameter int PHRS   = 128,
    parameter int GRPS   = 32,
    parameter int CYCS   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iEn,
    input  logic                     iBankRdy,
    input  logic [DATA_W-1:0]        iData,
    output logic                     oSwitch,
    output logic                     oRdEn,
    output logic [ADDR_W-1:0]        oAddr,
    output logic                     oSerial,
    output logic [DATA_W-1:0]        oParallel,
    output logic                     oValid,
    output logic [$clog2(GRPS)-1:0]  cntGrp,
    output logic [15:0]              oSecBcd,
    output logic                     oUnderrun
);

    localparam int c_slots  = 2 * DATA_W;
    localparam int c_slot_w = $clog2(c_slots);
    localparam int c_div_w  = $clog2(DIV);
    localparam int c_wrd_w  = (WRDS > 1) ? $clog2(WRDS) : 1;
    localparam int c_phr_w  = $clog2(PHRS);
    localparam int c_grp_w  = $clog2(GRPS);
    localparam int c_cyc_w  = (CYCS > 1) ? $clog2(CYCS) : 1;

    localparam logic [c_phr_w-1:0] c_p1  = c_phr_w'(PHRS - 1);
    localparam logic [c_phr_w-1:0] c_p3  = c_phr_w'(PHRS - 3);
    localparam logic [c_phr_w-1:0] c_p5  = c_phr_w'(PHRS - 5);
    localparam logic [c_phr_w-1:0] c_p7  = c_phr_w'(PHRS - 7);
    localparam logic [c_phr_w-1:0] c_p9  = c_phr_w'(PHRS - 9);
    localparam logic [c_phr_w-1:0] c_p11 = c_phr_w'(PHRS - 11);
    localparam logic [c_phr_w-1:0] c_p13 = c_phr_w'(PHRS - 13);
    localparam logic [c_phr_w-1:0] c_p15 = c_phr_w'(PHRS - 15);

    logic [c_div_w-1:0]  r_div;
    logic [c_slot_w-1:0] r_slot;
    logic [c_slots-1:0]  r_sr;
    logic [ADDR_W-1:0]   r_mem;
    logic [c_wrd_w-1:0]  r_word;
    logic [c_phr_w-1:0]  r_phr;
    logic [c_grp_w-1:0]  r_grp;
    logic [c_cyc_w-1:0]  r_cyc;

    logic                w_step;
    logic                w_last_slot;
    logic                w_rd;
    logic                w_load;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [c_slot_w-1:0] w_idx;
    logic                w_s0;
    logic                w_both;
    logic [c_slots-1:0]  w_tx;
    logic [c_slots-1:0]  w_dbl;
    logic [DATA_W-1:0]   w_par;
    logic [15:0]         w_sec_next;
    logic                w_bcd_carry;

    // Idle is only ever entered at a word boundary, so a non-zero div/slot means mid-word.
    assign w_step      = iEn || (r_div != '0) || (r_slot != '0);
    assign w_last_slot = (r_slot == c_slot_w'(c_slots - 1));
    assign w_rd        = w_last_slot && (r_div == c_div_w'(1));
    assign w_load      = w_last_slot && (r_div == c_div_w'(DIV - 1));
    assign w_addr_next = r_mem + ADDR_W'(1);
    assign w_idx       = c_slot_w'(c_slots - 1) - r_slot;
    assign cntGrp      = r_grp;

    // Markers follow the position counters of the word currently in the shift register.
    always_comb begin
        w_s0   = 1'b0;
        w_both = 1'b0;
        if (r_word == '0) begin
            w_s0 = ~r_phr[0];
            if (r_grp == c_grp_w'(GRPS - 1))
                w_both = r_phr inside {c_p15, c_p7, c_p5, c_p1};
            else
                w_both = r_phr inside {c_p13, c_p11, c_p9, c_p3};
            if ((r_cyc == '0) && (r_grp == '0) && (r_phr == c_phr_w'(15)))
                w_both = 1'b1;
        end
        w_tx              = r_sr;
        w_tx[c_slots-1]   = r_sr[c_slots-1] | w_s0 | w_both;
        w_tx[c_slots-2]   = r_sr[c_slots-2] | w_both;
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_bits
        assign w_dbl[2*j]   = iData[j];
        assign w_dbl[2*j+1] = iData[j];
        assign w_par[j]     = w_tx[2*j];
    end

    always_comb begin
        w_sec_next  = oSecBcd;
        w_bcd_carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (w_bcd_carry) begin
                if (oSecBcd[4*d +: 4] == 4'd9) begin
                    w_sec_next[4*d +: 4] = 4'd0;
                end else begin
                    w_sec_next[4*d +: 4] = oSecBcd[4*d +: 4] + 4'd1;
                    w_bcd_carry          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_slot    <= '0;
            r_sr      <= '0;
            r_mem     <= '0;
            r_word    <= '0;
            r_phr     <= '0;
            r_grp     <= '0;
            r_cyc     <= '0;
            oSwitch   <= 1'b0;
            oRdEn     <= 1'b0;
            oAddr     <= '0;
            oSerial   <= 1'b0;
            oParallel <= '0;
            oValid    <= 1'b0;
            oSecBcd   <= '0;
            oUnderrun <= 1'b0;
        end else begin
            oValid <= 1'b0;
            oRdEn  <= 1'b0;
            if (!w_step) begin
                oSerial <= 1'b0;
            end else begin
                if (w_load) begin
                    r_div  <= '0;
                    r_slot <= '0;
                end else if (r_div == c_div_w'(DIV - 1)) begin
                    r_div  <= '0;
                    r_slot <= r_slot + c_slot_w'(1);
                end else begin
                    r_div  <= r_div + c_div_w'(1);
                end

                if (r_div == '0) begin
                    oSerial <= w_tx[w_idx];
                    if (r_slot == '0) begin
                        oValid    <= 1'b1;
                        oParallel <= w_par;
                    end
                end

                if (w_rd) begin
                    oRdEn <= 1'b1;
                    oAddr <= w_addr_next;
                    if (w_addr_next == '0) begin
                        oSwitch <= ~oSwitch;
                        if (!iBankRdy)
                            oUnderrun <= 1'b1;
                    end
                end

                if (w_load) begin
                    r_sr  <= w_dbl;
                    r_mem <= r_mem + ADDR_W'(1);
                    if (r_word == c_wrd_w'(WRDS - 1)) begin
                        r_word <= '0;
                        if (r_phr == c_phr_w'(PHRS - 1)) begin
                            r_phr <= '0;
                            if (r_grp == c_grp_w'(GRPS - 1)) begin
                                r_grp <= '0;
                                if (r_cyc == c_cyc_w'(CYCS - 1)) begin
                                    r_cyc   <= '0;
                                    oSecBcd <= w_sec_next;
                                end else begin
                                    r_cyc <= r_cyc + c_cyc_w'(1);
                                end
                            end else begin
                                r_grp <= r_grp + c_grp_w'(1);
                            end
                        end else begin
                            r_phr <= r_phr + c_phr_w'(1);
                        end
                    end else begin
                        r_word <= r_word + c_wrd_w'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
